hub_port_arbiter: RTL and testbench

- Round-robin arbiter and transfer sequencer for the shared forwarding bus inside HUB2.
- Up to NUM_PORTS ingress ports request the bus, each with a packet length.
- The arbiter grants one port at a time and holds the grant for exactly that many accepted beats.
- Ends each transfer with done or abort, then enforces a one-cycle inter-packet gap.

---
 rtl/hub_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_hub_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub_port_arbiter.sv
// Round-robin arbiter and transfer sequencer for the HUB2 shared forwarding bus.
// One port owns the bus per packet; each transfer ends in done or abort followed by a one-cycle gap.
module hub_port_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int LEN_W     = 8,
  parameter int TIMEOUT   = 255,
  parameter int ID_W      = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_PORTS-1:0]       req,
  input  logic [NUM_PORTS*LEN_W-1:0] pkt_len,
  input  logic                       fwd_ready,
  output logic [NUM_PORTS-1:0]       grant,
  output logic [ID_W-1:0]            grant_id,
  output logic                       busy,
  output logic [LEN_W-1:0]           beat_cnt,
  output logic                       done,
  output logic                       abort
);

  localparam int ST_W = $clog2(TIMEOUT + 1);
  localparam int CW   = ID_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [ID_W-1:0]      rr_ptr, rr_ptr_nxt;
  logic [LEN_W-1:0]     len_q, len_nxt;
  logic [ST_W-1:0]      stall_cnt, stall_nxt;
  logic [NUM_PORTS-1:0] grant_nxt;
  logic [ID_W-1:0]      grant_id_nxt;
  logic                 busy_nxt;
  logic [LEN_W-1:0]     beat_nxt;
  logic                 done_nxt;
  logic                 abort_nxt;

  logic                 found;
  logic [ID_W-1:0]      sel;
  logic [CW-1:0]        cand;
  logic                 last_beat;
  logic                 timeout_hit;
  logic                 withdraw;
  logic                 leave;

  // Search starts one past the last served port so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = {1'b0, rr_ptr} + CW'(i);
      if (cand >= CW'(NUM_PORTS)) cand = cand - CW'(NUM_PORTS);
      if (!found && req[cand[ID_W-1:0]]) begin
        found = 1'b1;
        sel   = cand[ID_W-1:0];
      end
    end
  end

  assign last_beat   = (beat_cnt == len_q - LEN_W'(1));
  assign timeout_hit = (stall_cnt == ST_W'(TIMEOUT - 1));
  assign withdraw    = !req[grant_id];

  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    len_nxt      = len_q;
    stall_nxt    = stall_cnt;
    grant_nxt    = grant;
    grant_id_nxt = grant_id;
    busy_nxt     = busy;
    beat_nxt     = beat_cnt;
    done_nxt     = 1'b0;
    abort_nxt    = 1'b0;
    leave        = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt    = NUM_PORTS'(1) << sel;
          grant_id_nxt = sel;
          rr_ptr_nxt   = sel;
          len_nxt      = pkt_len[int'(sel)*LEN_W +: LEN_W];
          beat_nxt     = '0;
          stall_nxt    = '0;
          busy_nxt     = 1'b1;
          state_nxt    = XFER;
        end
      end
      XFER: begin
        // Completion outranks withdrawal, which outranks timeout.
        if (len_q == '0) begin
          done_nxt = 1'b1;
          leave    = 1'b1;
        end else if (fwd_ready && last_beat) begin
          beat_nxt = beat_cnt + LEN_W'(1);
          done_nxt = 1'b1;
          leave    = 1'b1;
        end else begin
          if (fwd_ready) begin
            beat_nxt  = beat_cnt + LEN_W'(1);
            stall_nxt = '0;
          end else begin
            stall_nxt = stall_cnt + ST_W'(1);
          end
          if (withdraw) begin
            abort_nxt = 1'b1;
            leave     = 1'b1;
          end else if (!fwd_ready && timeout_hit) begin
            abort_nxt = 1'b1;
            leave     = 1'b1;
          end
        end
        if (leave) begin
          grant_nxt = '0;
          busy_nxt  = 1'b0;
          stall_nxt = '0;
          state_nxt = GAP;
        end
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      beat_cnt  <= '0;
      done      <= 1'b0;
      abort     <= 1'b0;
      rr_ptr    <= ID_W'(NUM_PORTS - 1);
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      grant_id  <= grant_id_nxt;
      busy      <= busy_nxt;
      beat_cnt  <= beat_nxt;
      done      <= done_nxt;
      abort     <= abort_nxt;
      rr_ptr    <= rr_ptr_nxt;
      stall_cnt <= stall_nxt;
    end
  end

  // Packet length is only meaningful while a grant is held, so it needs no reset.
  always_ff @(posedge clk) begin
    len_q <= len_nxt;
  end

endmodule

// File: tb/tb_hub_port_arbiter.sv
// Directed and randomized bench for hub_port_arbiter against a transaction-level reference model.
module tb_hub_port_arbiter;

  localparam int NP = 4;
  localparam int LW = 8;
  localparam int TO = 4;
  localparam int IW = 2;

  logic             clk;
  logic             reset;
  logic [NP-1:0]    req;
  logic [NP*LW-1:0] pkt_len;
  logic             fwd_ready;
  logic [NP-1:0]    grant;
  logic [IW-1:0]    grant_id;
  logic             busy;
  logic [LW-1:0]    beat_cnt;
  logic             done;
  logic             abort;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus, how many beats it has moved, how long it has stalled.
  int m_owner;
  int m_last;
  int m_id;
  int m_len;
  int m_beats;
  int m_stall;
  bit m_gap;
  bit m_done;
  bit m_abort;

  hub_port_arbiter #(
    .NUM_PORTS(NP),
    .LEN_W    (LW),
    .TIMEOUT  (TO),
    .ID_W     (IW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .pkt_len  (pkt_len),
    .fwd_ready(fwd_ready),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .beat_cnt (beat_cnt),
    .done     (done),
    .abort    (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_step();
    bit fin;
    fin     = 1'b0;
    m_done  = 1'b0;
    m_abort = 1'b0;
    if (reset) begin
      m_owner = -1;
      m_last  = NP - 1;
      m_id    = 0;
      m_beats = 0;
      m_stall = 0;
      m_gap   = 1'b0;
      return;
    end
    if (m_gap) begin
      m_gap = 1'b0;
    end else if (m_owner < 0) begin
      for (int j = 1; j <= NP; j++) begin
        int p;
        p = (m_last + j) % NP;
        if (req[p]) begin
          m_owner = p;
          m_last  = p;
          m_id    = p;
          m_len   = int'(pkt_len[p*LW +: LW]);
          m_beats = 0;
          m_stall = 0;
          break;
        end
      end
    end else begin
      if (m_len == 0) begin
        m_done = 1'b1;
        fin    = 1'b1;
      end else begin
        if (fwd_ready) begin
          m_beats++;
          m_stall = 0;
        end else begin
          m_stall++;
        end
        if (m_beats == m_len) begin
          m_done = 1'b1;
          fin    = 1'b1;
        end else if (!req[m_owner]) begin
          m_abort = 1'b1;
          fin     = 1'b1;
        end else if (m_stall >= TO) begin
          m_abort = 1'b1;
          fin     = 1'b1;
        end
      end
      if (fin) begin
        m_owner = -1;
        m_gap   = 1'b1;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] eg;
    eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    chk({tag, "_grant"},    32'(grant),    eg);
    chk({tag, "_grant_id"}, 32'(grant_id), 32'(m_id));
    chk({tag, "_busy"},     32'(busy),     32'(m_owner >= 0));
    chk({tag, "_beat_cnt"}, 32'(beat_cnt), 32'(m_beats));
    chk({tag, "_done"},     32'(done),     32'(m_done));
    chk({tag, "_abort"},    32'(abort),    32'(m_abort));
    chk({tag, "_onehot"},   32'($countones(grant) <= 1), 32'd1);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step("reset");
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    req       = '0;
    pkt_len   = '0;
    fwd_ready = 1'b0;
    m_owner   = -1;
    m_last    = NP - 1;
    m_id      = 0;
    m_len     = 0;
    m_beats   = 0;
    m_stall   = 0;
    m_gap     = 1'b0;
    m_done    = 1'b0;
    m_abort   = 1'b0;

    // Reset state
    do_reset();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy",  32'(busy),  32'h0);

    // Single request, length 3
    req = 4'b0010; pkt_len[1*LW +: LW] = 8'd3; fwd_ready = 1'b1;
    step("single");
    chk("single_grant", 32'(grant), 32'h2);
    step("single");
    step("single");
    step("single");
    chk("single_done", 32'(done), 32'h1);
    chk("single_beats", 32'(beat_cnt), 32'd3);
    req = '0;
    step("single_gap");
    chk("single_gap_grant", 32'(grant), 32'h0);
    step("single_idle");

    // Round-robin across four steady requesters
    do_reset();
    req = 4'b1111;
    for (int p = 0; p < NP; p++) pkt_len[p*LW +: LW] = 8'd1;
    for (int k = 0; k < 5; k++) begin
      step("rr");
      chk("rr_grant", 32'(grant), 32'd1 << (k % NP));
      step("rr_done");
      step("rr_gap");
    end
    req = '0;
    step("rr_end");

    // Stall timeout on port 2, then next grant must go to port 3
    do_reset();
    req = 4'b0100; pkt_len[2*LW +: LW] = 8'd5; fwd_ready = 1'b0;
    step("to");
    chk("to_grant", 32'(grant), 32'h4);
    for (int k = 0; k < 4; k++) begin
      step("to_stall");
      chk("to_abort", 32'(abort), (k == 3) ? 32'd1 : 32'd0);
    end
    chk("to_beats", 32'(beat_cnt), 32'd0);
    req = 4'b1100; pkt_len[3*LW +: LW] = 8'd2; fwd_ready = 1'b1;
    step("to_gap");
    step("to_next");
    chk("to_next_grant", 32'(grant), 32'h8);
    chk("to_next_id", 32'(grant_id), 32'd3);
    req = '0;
    step("to_end");
    step("to_end");
    step("to_end");

    // Backpressure pattern 1,0,1,1,0,1 on a 4-beat packet
    do_reset();
    req = 4'b0001; pkt_len[0*LW +: LW] = 8'd4;
    step("bp");
    for (int k = 0; k < 6; k++) begin
      fwd_ready = (k == 1 || k == 4) ? 1'b0 : 1'b1;
      step("bp_beat");
      chk("bp_abort", 32'(abort), 32'd0);
    end
    chk("bp_done", 32'(done), 32'd1);
    chk("bp_beats", 32'(beat_cnt), 32'd4);
    req = '0;
    step("bp_gap");

    // Withdrawal after 2 beats, then a zero-length packet on port 1
    do_reset();
    req = 4'b0001; pkt_len[0*LW +: LW] = 8'd5; fwd_ready = 1'b1;
    step("wd");
    step("wd_beat");
    step("wd_beat");
    req = 4'b0000; fwd_ready = 1'b0;
    step("wd_drop");
    chk("wd_abort", 32'(abort), 32'd1);
    chk("wd_beats", 32'(beat_cnt), 32'd2);
    req = 4'b0010; pkt_len[1*LW +: LW] = 8'd0; fwd_ready = 1'b1;
    step("zl_gap");
    step("zl_grant");
    chk("zl_grant", 32'(grant), 32'h2);
    req = 4'b0000;
    step("zl_done");
    chk("zl_done", 32'(done), 32'd1);
    chk("zl_beats", 32'(beat_cnt), 32'd0);
    step("zl_gap2");

    // Reset in the middle of an 8-beat transfer
    do_reset();
    req = 4'b0100; pkt_len[2*LW +: LW] = 8'd8; fwd_ready = 1'b1;
    step("mr");
    step("mr_beat");
    step("mr_beat");
    step("mr_beat");
    chk("mr_beats", 32'(beat_cnt), 32'd3);
    reset = 1'b1;
    step("mr_reset");
    chk("mr_grant", 32'(grant), 32'h0);
    chk("mr_busy",  32'(busy),  32'h0);
    chk("mr_done",  32'(done),  32'h0);
    chk("mr_abort", 32'(abort), 32'h0);
    reset = 1'b0; req = 4'b1111;
    step("mr_restart");
    chk("mr_restart_grant", 32'(grant), 32'h1);

    // Randomized traffic: sticky requests, random withdrawals, varying backpressure
    for (int i = 0; i < 3000; i++) begin
      int low_pct;
      low_pct = ((i / 250) % 2 == 1) ? 60 : 15;
      for (int p = 0; p < NP; p++) begin
        if (req[p]) begin
          if (((m_done || m_abort) && m_id == p && $urandom_range(0, 99) < 60) ||
              $urandom_range(0, 99) < 3)
            req[p] = 1'b0;
        end else if ($urandom_range(0, 99) < 30) begin
          req[p] = 1'b1;
        end
        pkt_len[p*LW +: LW] = LW'($urandom_range(0, 6));
      end
      fwd_ready = ($urandom_range(0, 99) >= low_pct);
      reset     = ($urandom_range(0, 499) == 0);
      step("rand");
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
